rv32i_id_stage_v2: RTL and testbench
====================================

Name: rv32i_id_stage_v2

Overview:
- Parametrised next-generation RV32I decode stage. Sits between the fetch stage and the execute stage.
- Generalises decode with XLEN, a configurable number of forwarding sources and a configurable flush depth.
- Adds load-use stall detection, a RUN/FLUSH/HALT control FSM and a valid qualifier on the pipeline register.
- Resolves JAL, JALR and conditional branches in decode, reporting a redirect to fetch.

Parameters:
- XLEN, 32, data/address width; immediates are sign-extended to XLEN.
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (execute), higher indices are older.
- FLUSH_CYCLES, 1, number of decode slots squashed after a redirect; legal range 1..3.
- NOP_IW, 32'h00000013, bubble instruction word (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iw_in  in  32  instruction word from fetch
- pc_in  in  XLEN  PC of iw_in
- valid_in  in  1  iw_in/pc_in hold a real instruction
- rs1_data_in, rs2_data_in  in  XLEN  register file read data
- fwd_en  in  NUM_FWD  per-source writeback enable
- fwd_reg  in  5*NUM_FWD  per-source destination register, packed (source i at [5i+4:5i])
- fwd_data  in  XLEN*NUM_FWD  per-source result, packed
- ex_is_load  in  1  instruction currently in execute is a load
- ex_load_reg  in  5  destination register of that load
- rs1_reg, rs2_reg  out  5  combinational iw_in[19:15] / iw_in[24:20] to the register file
- stall_out  out  1  combinational; fetch must hold iw_in/pc_in
- jump_en_out  out  1  combinational redirect request to fetch
- jump_addr  out  XLEN  combinational redirect target; 0 when jump_en_out=0
- iw_out  out  32  registered instruction to execute
- pc_out  out  XLEN  registered PC
- wb_reg  out  5  registered iw[11:7]
- wb_en_out  out  1  registered writeback enable
- valid_out  out  1  registered valid
- rs1_data_out, rs2_data_out  out  XLEN  registered forwarded operands
- halted  out  1  registered; high in HALT

Behaviour:
- Reset (async): state=RUN, flush count=0, iw_out=NOP_IW, and pc_out, wb_reg, wb_en_out, valid_out, rs1_data_out, rs2_data_out and halted all 0.
- Forwarding (combinational), per operand:
  - Selects the lowest index i with fwd_en[i]=1, fwd_reg[i]==rsN_reg and rsN_reg!=0.
  - Otherwise uses rsN_data_in. x0 is never forwarded.
  - Branch compare and JALR use the forwarded values.
- Operand use by opcode:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 used by BRANCH, STORE and OP.
- Load-use hazard (RUN only):
  - Condition: valid_in & ex_is_load & ex_load_reg!=0 & a used rsN==ex_load_reg.
  - Response: stall_out=1, jump_en_out=0, and a bubble is issued next edge (iw_out=NOP_IW, valid_out=0, wb_en_out=0). Exactly one bubble per hazard.
- wb_en_out=0 for STORE, BRANCH, FENCE, SYSTEM and for bubbles. It is 1 otherwise, including JAL/JALR (link write to rd).
- Redirect (RUN, valid_in, no stall):
  - JAL: pc_in + J-imm.
  - JALR: (rs1 + I-imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: pc_in + B-imm when the condition holds.
  - funct3 010/011 never branch.
  - On redirect: jump_en_out=1 for one cycle, the jump instruction itself is registered with valid_out=1, and the state moves to FLUSH with count=FLUSH_CYCLES.
- FLUSH:
  - Each edge registers a bubble and decrements the count; return to RUN when the count reaches 0.
  - jump_en_out=0 and stall_out=0; hazards are ignored.
- SYSTEM (opcode 1110011):
  - Registered as a bubble; halted=1 next edge; state goes to HALT.
  - In HALT: stall_out=1, bubbles only, jump_en_out=0. Only reset exits HALT.
- Priority within a cycle: HALT > FLUSH > load-use stall > SYSTEM > redirect > normal issue.
- valid_in=0 in RUN: a bubble is registered and no hazard or redirect is raised.
- Address arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro: RV32I_ID_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_out (1 bit, registered, reset 0).
  - A redirect whose target has bit 1 set suppresses jump_en_out, issues a bubble, sets misalign_out=1 and enters HALT.
- Undefined:
  - The port is absent and targets are used unchecked.

Test Plan:
- Forwarding priority: rs1=x5, fwd_en=3'b111, all fwd_reg=5, fwd_data={30,20,10} (source 2 = 30 ... source 0 = 10) -> rs1_data_out=10. Same with rs1=x0 -> rs1_data_in.
- Load-use: ex_is_load=1, ex_load_reg=7, add x1,x7,x2 -> stall_out=1 one cycle, one bubble (valid_out=0), then add issued with valid_out=1.
- BEQ taken, FLUSH_CYCLES=2: pc_in=0x100, rs1=rs2=4, imm=+16 -> jump_en_out=1, jump_addr=0x110, BEQ registered, next 2 outputs NOP_IW with valid_out=0.
- JALR: rs1 forwarded 0x203, imm=+4 -> jump_addr=0x206. With RV32I_ID_MISALIGN_TRAP_EN: jump_en_out=0, misalign_out=1, halted=1.
- EBREAK: iw_in=0x00100073 -> iw_out=NOP_IW, halted=1, stall_out held high. Reset asserted mid-HALT -> all outputs return to reset values asynchronously.
- BLTU vs BLT: rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken.

Source files
------------

// File: rtl/rv32i_id_stage_v2.sv
// RV32I decode stage: operand forwarding, load-use stall, decode-time branch/jump resolve, RUN/FLUSH/HALT control.
// Optional: define RV32I_ID_MISALIGN_TRAP_EN to trap redirects whose target has bit 1 set (adds misalign_out).
module rv32i_id_stage_v2 #(
    parameter int          XLEN         = 32,
    parameter int          NUM_FWD      = 3,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_IW       = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             iw_in,
    input  logic [XLEN-1:0]         pc_in,
    input  logic                    valid_in,
    input  logic [XLEN-1:0]         rs1_data_in,
    input  logic [XLEN-1:0]         rs2_data_in,
    input  logic [NUM_FWD-1:0]      fwd_en,
    input  logic [5*NUM_FWD-1:0]    fwd_reg,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_load_reg,
    output logic [4:0]              rs1_reg,
    output logic [4:0]              rs2_reg,
    output logic                    stall_out,
    output logic                    jump_en_out,
    output logic [XLEN-1:0]         jump_addr,
    output logic [31:0]             iw_out,
    output logic [XLEN-1:0]         pc_out,
    output logic [4:0]              wb_reg,
    output logic                    wb_en_out,
    output logic                    valid_out,
    output logic [XLEN-1:0]         rs1_data_out,
    output logic [XLEN-1:0]         rs2_data_out,
`ifdef RV32I_ID_MISALIGN_TRAP_EN
    output logic                    misalign_out,
`endif
    output logic                    halted
);
    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_FENCE = 7'b0001111, OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP = 7'b0110011, OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111, OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    state_t          r_state, w_state_nx;
    logic [1:0]      r_flush_cnt, w_flush_cnt_nx;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_use_rs1, w_use_rs2, w_hazard, w_is_sys, w_wb_en;
    logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd, w_imm_i, w_imm_b, w_imm_j, w_jalr_sum, w_target;
    logic            w_br_take, w_redir_req, w_misalign, w_issue, w_trap_mis;

    assign w_opc   = iw_in[6:0];
    assign w_f3    = iw_in[14:12];
    assign rs1_reg = iw_in[19:15];
    assign rs2_reg = iw_in[24:20];

    assign w_use_rs1 = w_opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    assign w_use_rs2 = w_opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    assign w_is_sys  = (w_opc == OPC_SYSTEM);
    assign w_wb_en   = !(w_opc inside {OPC_STORE, OPC_BRANCH, OPC_FENCE, OPC_SYSTEM});

    assign w_imm_i = {{(XLEN-12){iw_in[31]}}, iw_in[31:20]};
    assign w_imm_b = {{(XLEN-13){iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-21){iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

    // Walk from oldest to youngest so the lowest matching index wins.
    always_comb begin
        w_rs1_fwd = rs1_data_in;
        w_rs2_fwd = rs2_data_in;
        for (int i = NUM_FWD-1; i >= 0; i--) begin
            if (fwd_en[i] && fwd_reg[5*i +: 5] == rs1_reg && rs1_reg != 5'd0)
                w_rs1_fwd = fwd_data[XLEN*i +: XLEN];
            if (fwd_en[i] && fwd_reg[5*i +: 5] == rs2_reg && rs2_reg != 5'd0)
                w_rs2_fwd = fwd_data[XLEN*i +: XLEN];
        end
    end

    assign w_hazard = valid_in && ex_is_load && ex_load_reg != 5'd0 &&
                      ((w_use_rs1 && rs1_reg == ex_load_reg) || (w_use_rs2 && rs2_reg == ex_load_reg));

    always_comb begin
        case (w_f3)
            3'b000:  w_br_take = (w_rs1_fwd == w_rs2_fwd);
            3'b001:  w_br_take = (w_rs1_fwd != w_rs2_fwd);
            3'b100:  w_br_take = ($signed(w_rs1_fwd) <  $signed(w_rs2_fwd));
            3'b101:  w_br_take = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
            3'b110:  w_br_take = (w_rs1_fwd <  w_rs2_fwd);
            3'b111:  w_br_take = (w_rs1_fwd >= w_rs2_fwd);
            default: w_br_take = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_rs1_fwd + w_imm_i;

    always_comb begin
        w_redir_req = 1'b0;
        w_target    = '0;
        case (w_opc)
            OPC_JAL:    begin w_redir_req = 1'b1;      w_target = pc_in + w_imm_j; end
            OPC_JALR:   begin w_redir_req = 1'b1;      w_target = {w_jalr_sum[XLEN-1:1], 1'b0}; end
            OPC_BRANCH: begin w_redir_req = w_br_take; w_target = pc_in + w_imm_b; end
            default: ;
        endcase
    end

`ifdef RV32I_ID_MISALIGN_TRAP_EN
    assign w_misalign = w_target[1];
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nx;
            r_flush_cnt <= w_flush_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_flush_cnt_nx = r_flush_cnt;
        case (r_state)
            S_RUN: if (valid_in && !w_hazard) begin
                if (w_is_sys || (w_redir_req && w_misalign)) begin
                    w_state_nx = S_HALT;
                end else if (w_redir_req) begin
                    w_state_nx     = S_FLUSH;
                    w_flush_cnt_nx = 2'(FLUSH_CYCLES);
                end
            end
            S_FLUSH: begin
                w_flush_cnt_nx = r_flush_cnt - 2'd1;
                if (r_flush_cnt == 2'd1) w_state_nx = S_RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_out   = 1'b0;
        jump_en_out = 1'b0;
        jump_addr   = '0;
        w_issue     = 1'b0;
        w_trap_mis  = 1'b0;
        case (r_state)
            S_HALT:  stall_out = 1'b1;
            S_FLUSH: ;
            default: if (valid_in) begin
                if (w_hazard) begin
                    stall_out = 1'b1;
                end else if (w_is_sys) begin
                    w_issue = 1'b0;
                end else if (w_redir_req && w_misalign) begin
                    w_trap_mis = 1'b1;
                end else begin
                    w_issue = 1'b1;
                    if (w_redir_req) begin
                        jump_en_out = 1'b1;
                        jump_addr   = w_target;
                    end
                end
            end
        endcase
    end

    // Anything not issued becomes a bubble with zeroed side fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iw_out       <= NOP_IW;
            pc_out       <= '0;
            wb_reg       <= 5'd0;
            wb_en_out    <= 1'b0;
            valid_out    <= 1'b0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            halted       <= 1'b0;
        end else begin
            halted <= (w_state_nx == S_HALT);
            if (w_issue) begin
                iw_out       <= iw_in;
                pc_out       <= pc_in;
                wb_reg       <= iw_in[11:7];
                wb_en_out    <= w_wb_en;
                valid_out    <= 1'b1;
                rs1_data_out <= w_rs1_fwd;
                rs2_data_out <= w_rs2_fwd;
            end else begin
                iw_out       <= NOP_IW;
                pc_out       <= '0;
                wb_reg       <= 5'd0;
                wb_en_out    <= 1'b0;
                valid_out    <= 1'b0;
                rs1_data_out <= '0;
                rs2_data_out <= '0;
            end
        end
    end

`ifdef RV32I_ID_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           misalign_out <= 1'b0;
        else if (w_trap_mis) misalign_out <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rv32i_id_stage_v2.sv
// Randomized scoreboard bench for rv32i_id_stage_v2 (FLUSH_CYCLES=2) with a spec-level reference model.
module tb_rv32i_id_stage_v2;
    localparam int          NF  = 3;
    localparam int          FC  = 2;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_FENCE = 7'b0001111, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_R = 7'b0110011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_JAL = 7'b1101111, OP_SYS = 7'b1110011;
    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

    logic           clk = 1'b0, reset = 1'b1;
    logic [31:0]    iw_in = NOP, pc_in = '0, rs1_data_in = '0, rs2_data_in = '0;
    logic           valid_in = 1'b0, ex_is_load = 1'b0;
    logic [NF-1:0]  fwd_en = '0;
    logic [5*NF-1:0]  fwd_reg = '0;
    logic [32*NF-1:0] fwd_data = '0;
    logic [4:0]     ex_load_reg = '0;
    logic [4:0]     rs1_reg, rs2_reg, wb_reg;
    logic           stall_out, jump_en_out, wb_en_out, valid_out, halted;
    logic [31:0]    jump_addr, iw_out, pc_out, rs1_data_out, rs2_data_out;
`ifdef RV32I_ID_MISALIGN_TRAP_EN
    logic           misalign_out;
`endif

    always #5 clk = ~clk;

    rv32i_id_stage_v2 #(.XLEN(32), .NUM_FWD(NF), .FLUSH_CYCLES(FC), .NOP_IW(NOP)) dut (
        .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in), .valid_in(valid_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .fwd_en(fwd_en), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data), .ex_is_load(ex_is_load), .ex_load_reg(ex_load_reg),
        .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .stall_out(stall_out), .jump_en_out(jump_en_out),
        .jump_addr(jump_addr), .iw_out(iw_out), .pc_out(pc_out), .wb_reg(wb_reg), .wb_en_out(wb_en_out),
        .valid_out(valid_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
`ifdef RV32I_ID_MISALIGN_TRAP_EN
        .misalign_out(misalign_out),
`endif
        .halted(halted));

    typedef struct {
        logic [31:0] iw, pc, d1, d2;
        logic [4:0]  rd;
        logic        wbe, vld, hlt, mis;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0;
    int   mode = M_RUN, flush_left = 0;
    logic mis_st = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // First enabled source (youngest first) naming the register supplies the value; x0 never forwards.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dflt);
        if (r == 5'd0) return dflt;
        for (int i = 0; i < NF; i++)
            if (fwd_en[i] && fwd_reg[5*i +: 5] == r) return fwd_data[32*i +: 32];
        return dflt;
    endfunction

    task automatic model_step();
        exp_t        e;
        logic        st, je, take, issue, u1, u2;
        logic [31:0] ja, a, b, tgt, iimm, bimm, jimm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  r1, r2;
        int          nm;
        op = iw_in[6:0]; f3 = iw_in[14:12]; r1 = iw_in[19:15]; r2 = iw_in[24:20];
        st = 0; je = 0; take = 0; issue = 0; ja = 0; tgt = 0; nm = mode;
        a = fwd(r1, rs1_data_in);
        b = fwd(r2, rs2_data_in);
        iimm = {{20{iw_in[31]}}, iw_in[31:20]};
        bimm = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
        jimm = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};
        u1 = op inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_R};
        u2 = op inside {OP_BR, OP_ST, OP_R};
        if (mode == M_HALT) st = 1;
        else if (mode == M_FLUSH) begin
            flush_left--;
            if (flush_left == 0) nm = M_RUN;
        end else if (!valid_in) begin
            issue = 0;
        end else if (ex_is_load && ex_load_reg != 0 && ((u1 && r1 == ex_load_reg) || (u2 && r2 == ex_load_reg))) begin
            st = 1;
        end else if (op == OP_SYS) begin
            nm = M_HALT;
        end else begin
            case (op)
                OP_JAL:  begin take = 1; tgt = pc_in + jimm; end
                OP_JALR: begin take = 1; tgt = (a + iimm) & 32'hFFFF_FFFE; end
                OP_BR: begin
                    tgt = pc_in + bimm;
                    case (f3)
                        3'd0: take = (a == b);
                        3'd1: take = (a != b);
                        3'd4: take = ($signed(a) <  $signed(b));
                        3'd5: take = ($signed(a) >= $signed(b));
                        3'd6: take = (a <  b);
                        3'd7: take = (a >= b);
                        default: take = 0;
                    endcase
                end
                default: take = 0;
            endcase
            issue = 1;
`ifdef RV32I_ID_MISALIGN_TRAP_EN
            if (take && tgt[1]) begin
                issue = 0; take = 0; nm = M_HALT; mis_st = 1;
            end
`endif
            if (take) begin
                je = 1; ja = tgt; nm = M_FLUSH; flush_left = FC;
            end
        end
        chk("stall_out", 32'(stall_out), 32'(st));
        chk("jump_en_out", 32'(jump_en_out), 32'(je));
        chk("jump_addr", jump_addr, ja);
        chk("rs1_reg", 32'(rs1_reg), 32'(r1));
        chk("rs2_reg", 32'(rs2_reg), 32'(r2));
        e.iw = issue ? iw_in : NOP;
        e.pc = pc_in; e.d1 = a; e.d2 = b; e.rd = iw_in[11:7];
        e.vld = issue;
        e.wbe = issue && !(op inside {OP_ST, OP_BR, OP_FENCE, OP_SYS});
        e.hlt = (nm == M_HALT);
        e.mis = mis_st;
        q.push_back(e);
        mode = nm;
    endtask

    // Inputs are applied at posedge+1; the model samples at negedge, then we return at the next posedge+1.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 0;
        #2;
        reset = 1;
        #1;
        chk("rst_iw_out", iw_out, NOP);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_en", 32'(wb_en_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_rs1_data", rs1_data_out, 32'd0);
        chk("rst_rs2_data", rs2_data_out, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
`ifdef RV32I_ID_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(misalign_out), 32'd0);
`endif
        q.delete();
        mode = M_RUN; flush_left = 0; mis_st = 0;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_r(input int rs1, input int rs2, input int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OP_R};
    endfunction

    task automatic rand_inputs();
        logic [6:0] ops[9];
        logic [6:0] op;
        ops = '{OP_R, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_FENCE, OP_LUI};
        op = ops[$urandom_range(0, 8)];
`ifdef RV32I_ID_MISALIGN_TRAP_EN
        if (op == OP_JALR) op = OP_R;
`endif
        iw_in = $urandom;
        iw_in[6:0]   = op;
        iw_in[19:15] = 5'($urandom_range(0, 7));
        iw_in[24:20] = 5'($urandom_range(0, 7));
        iw_in[8]  = 1'b0;
        iw_in[21] = 1'b0;
        pc_in = $urandom & 32'hFFFF_FFFC;
        valid_in = ($urandom_range(0, 9) != 0);
        rs1_data_in = $urandom;
        rs2_data_in = $urandom;
        fwd_en = 3'($urandom);
        for (int i = 0; i < NF; i++) fwd_reg[5*i +: 5] = 5'($urandom_range(0, 7));
        fwd_data = {$urandom, $urandom, $urandom};
        ex_is_load = ($urandom_range(0, 2) == 0);
        ex_load_reg = 5'($urandom_range(0, 7));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("iw_out", iw_out, e.iw);
                chk("valid_out", 32'(valid_out), 32'(e.vld));
                chk("wb_en_out", 32'(wb_en_out), 32'(e.wbe));
                chk("halted", 32'(halted), 32'(e.hlt));
`ifdef RV32I_ID_MISALIGN_TRAP_EN
                chk("misalign_out", 32'(misalign_out), 32'(e.mis));
`endif
                if (e.vld) begin
                    chk("pc_out", pc_out, e.pc);
                    chk("wb_reg", 32'(wb_reg), 32'(e.rd));
                    chk("rs1_data_out", rs1_data_out, e.d1);
                    chk("rs2_data_out", rs2_data_out, e.d2);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1);
    end

    initial begin : stim
        @(posedge clk);
        #1;
        do_reset();

        // Forwarding priority and x0 exclusion
        iw_in = enc_i(1, 5, 3, OP_IMM); valid_in = 1; rs1_data_in = 32'd99;
        fwd_en = 3'b111; fwd_reg = {5'd5, 5'd5, 5'd5}; fwd_data = {32'd30, 32'd20, 32'd10};
        tick();
        chk("fwd_priority", rs1_data_out, 32'd10);
        iw_in = enc_i(1, 0, 3, OP_IMM);
        tick();
        chk("fwd_x0", rs1_data_out, 32'd99);

        // Load-use: one stall/bubble, then the add issues
        fwd_en = '0; ex_is_load = 1; ex_load_reg = 5'd7; iw_in = enc_r(7, 2, 1);
        tick();
        chk("ldu_bubble", 32'(valid_out), 32'd0);
        ex_is_load = 0;
        tick();
        chk("ldu_issue", 32'(valid_out), 32'd1);

        // BEQ taken, then two squashed slots
        pc_in = 32'h100; iw_in = enc_b(16, 1, 2, 0); rs1_data_in = 32'd4; rs2_data_in = 32'd4;
        #1;
        chk("beq_target", jump_addr, 32'h110);
        tick();
        iw_in = enc_r(3, 4, 5);
        repeat (FC) begin
            tick();
            chk("beq_flush_bubble", 32'(valid_out), 32'd0);
        end
        tick();

        // Signed vs unsigned compare
        pc_in = 32'h200; iw_in = enc_b(8, 1, 2, 4); rs1_data_in = 32'hFFFF_FFFF; rs2_data_in = 32'd1;
        #1;
        chk("blt_taken", 32'(jump_en_out), 32'd1);
        tick();
        valid_in = 0;
        repeat (FC) tick();
        valid_in = 1; iw_in = enc_b(8, 1, 2, 6);
        #1;
        chk("bltu_not_taken", 32'(jump_en_out), 32'd0);
        tick();

        // JALR through forwarded rs1
        iw_in = enc_i(4, 6, 1, OP_JALR); fwd_en = 3'b001; fwd_reg = {10'd0, 5'd6}; fwd_data = {64'd0, 32'h203};
        #1;
`ifdef RV32I_ID_MISALIGN_TRAP_EN
        chk("jalr_trap_noredirect", 32'(jump_en_out), 32'd0);
        tick();
        chk("jalr_misalign", 32'(misalign_out), 32'd1);
        chk("jalr_halted", 32'(halted), 32'd1);
        do_reset();
`else
        chk("jalr_target", jump_addr, 32'h206);
        tick();
        valid_in = 0;
        repeat (FC) tick();
`endif

        // Randomized traffic
        repeat (600) begin
            rand_inputs();
            tick();
        end
        valid_in = 0;
        repeat (FC + 1) tick();

        // EBREAK -> HALT, held until async reset
        valid_in = 1; ex_is_load = 0; iw_in = 32'h00100073;
        tick();
        chk("ebreak_bubble", iw_out, NOP);
        chk("ebreak_halted", 32'(halted), 32'd1);
        repeat (4) begin
            rand_inputs();
            tick();
            chk("halt_stall", 32'(stall_out), 32'd1);
        end
        do_reset();

        valid_in = 1; fwd_en = '0; ex_is_load = 0; iw_in = enc_r(1, 2, 3);
        rs1_data_in = 32'h1234; rs2_data_in = 32'h5678;
        repeat (2) tick();
        valid_in = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
